cla_pipe_adder: RTL

- Pipelined WIDTH-bit adder built from 4-bit carry-lookahead groups, with a second-level lookahead carry unit across the groups.
- Consumes the per-group propagate/generate (PG/GG) signals that the 4-bit CLA group produces.
- Registers the operands across two stages behind a valid/ready handshake.
- Sits on the datapath between operand sources and any downstream consumer that can apply backpressure.

---
 rtl/cla_pipe_adder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined WIDTH-bit adder built from 4-bit carry-lookahead groups with
// a second-level lookahead unit. The optional out_ovf port is enabled by CLA_PIPE_OVF_EN.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_pg,
  output logic             out_gg
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned NG = WIDTH / 4;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  logic adv1, adv2, acc1;

  logic [WIDTH-1:0] p_in, g_in;
  logic [NG-1:0]    pg_in, gg_in;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic [NG-1:0]    s1_pg, s1_gg;
  logic             s1_cin;

  logic [NG:0]      gc;
  logic [WIDTH:0]   bc;
  logic [WIDTH-1:0] sum2;
  logic             gg_all;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_cout, s2_pg, s2_gg;
`ifdef CLA_PIPE_OVF_EN
  logic             s2_ovf;
`endif

  assign adv2     = s1_valid & (~s2_valid | out_ready);
  assign adv1     = ~s1_valid | adv2;
  assign acc1     = in_valid & adv1;
  assign in_ready = adv1;

  always_comb begin
    p_in  = in_a ^ in_b;
    g_in  = in_a & in_b;
    pg_in = '0;
    gg_in = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      pg_in[k] = &p_in[4*k +: 4];
      gg_in[k] = g_in[4*k+3]
               | (p_in[4*k+3] & g_in[4*k+2])
               | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
               | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
    end
  end

  // Every carry is an explicit OR of product terms over the registered PG/GG or
  // P/G, so no carry depends on a previously computed carry except the group input.
  always_comb begin
    logic term;
    logic acc;
    term   = 1'b0;
    acc    = 1'b0;
    gc     = '0;
    gc[0]  = s1_cin;
    for (int unsigned k = 1; k <= NG; k++) begin
      acc = 1'b0;
      for (int unsigned j = 0; j < k; j++) begin
        term = s1_gg[j];
        for (int unsigned m = j + 1; m < k; m++) term = term & s1_pg[m];
        acc = acc | term;
      end
      term = s1_cin;
      for (int unsigned m = 0; m < k; m++) term = term & s1_pg[m];
      gc[k] = acc | term;
    end

    gg_all = 1'b0;
    for (int unsigned j = 0; j < NG; j++) begin
      term = s1_gg[j];
      for (int unsigned m = j + 1; m < NG; m++) term = term & s1_pg[m];
      gg_all = gg_all | term;
    end

    bc = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        acc = 1'b0;
        for (int unsigned j = 0; j < i; j++) begin
          term = s1_g[4*k+j];
          for (int unsigned m = j + 1; m < i; m++) term = term & s1_p[4*k+m];
          acc = acc | term;
        end
        term = gc[k];
        for (int unsigned m = 0; m < i; m++) term = term & s1_p[4*k+m];
        bc[4*k+i] = acc | term;
      end
    end
    bc[WIDTH] = gc[NG];
    sum2      = s1_p ^ bc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv1)          s1_valid <= in_valid;
      if (adv2)          s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc1) begin
      s1_p   <= p_in;
      s1_g   <= g_in;
      s1_pg  <= pg_in;
      s1_gg  <= gg_in;
      s1_cin <= in_cin;
    end
    if (adv2) begin
      s2_sum  <= sum2;
      s2_cout <= gc[NG];
      s2_pg   <= &s1_pg;
      s2_gg   <= gg_all;
`ifdef CLA_PIPE_OVF_EN
      s2_ovf  <= bc[WIDTH-1] ^ bc[WIDTH];
`endif
    end
  end

  assign out_valid = s2_valid;
  assign out_sum   = s2_sum;
  assign out_cout  = s2_cout;
  assign out_pg    = s2_pg;
  assign out_gg    = s2_gg;
`ifdef CLA_PIPE_OVF_EN
  assign out_ovf   = s2_ovf;
`endif

endmodule
